cordic_vectoring_rolled: RTL and testbench

Iterative CORDIC in vectoring mode. It is the inverse of the rotation-mode cosine unit: it takes a Cartesian point (x, y) and returns the polar angle atan2(y, x) and the gain-compensated magnitude sqrt(x²+y²). It sits next to the cosine unit in the floating-point datapath and shares its fixed-point format (22-bit signed, 20 fractional bits). It uses the same start/`done` strobe style, and each cycle it performs several micro-rotations.

---
 rtl/cordic_vectoring_rolled.sv | 175 +++++++++++++++++
 tb/tb_cordic_vectoring_rolled.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vectoring_rolled.sv
`default_nettype none
// ============================================================================
// cordic_vectoring_rolled
//   Iterative vectoring CORDIC, STEPS micro-rotations per clock:
//   (x, y) -> atan2(y, x) and gain-compensated magnitude, Q1.20 / Q2.20.
//   Rev 1.0
// ============================================================================
module cordic_vectoring_rolled #(
    parameter int ITERS = 16,
    parameter int STEPS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_en,
    input  logic signed [21:0] x_in,
    input  logic signed [21:0] y_in,
    output logic signed [22:0] angle_out,
    output logic        [21:0] mag_out,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PREROT = 2'd1,
        ITER   = 2'd2,
        SCALE  = 2'd3
    } state_t;

    localparam logic signed [22:0] HALF_PI = 23'sh1921FB;
    localparam logic signed [22:0] PI      = 23'sh3243F6;
    localparam logic signed [22:0] NEG_PI  = -23'sh3243F6;
    localparam logic signed [47:0] K_GAIN  = 48'sh09B74E;
    localparam logic signed [47:0] MAG_MAX = 48'sh1FFFFF;
    localparam logic [4:0]         ITERS_W = 5'(ITERS);
    localparam logic [4:0]         STEPS_W = 5'(STEPS);

    state_t             state;
    logic signed [23:0] x;
    logic signed [23:0] y;
    logic signed [22:0] z;
    logic [4:0]         i;
    logic               zero_f;

    function automatic logic signed [22:0] atan_lut(input logic [4:0] k);
        case (k)
            5'd0:    atan_lut = 23'sh0C90FD;
            5'd1:    atan_lut = 23'sh076B19;
            5'd2:    atan_lut = 23'sh03EB6E;
            5'd3:    atan_lut = 23'sh01FD5B;
            5'd4:    atan_lut = 23'sh00FFAA;
            5'd5:    atan_lut = 23'sh007FF5;
            5'd6:    atan_lut = 23'sh003FFE;
            5'd7:    atan_lut = 23'sh001FFF;
            5'd8:    atan_lut = 23'sh000FFF;
            5'd9:    atan_lut = 23'sh0007FF;
            5'd10:   atan_lut = 23'sh0003FF;
            5'd11:   atan_lut = 23'sh0001FF;
            5'd12:   atan_lut = 23'sh0000FF;
            5'd13:   atan_lut = 23'sh00007F;
            5'd14:   atan_lut = 23'sh00003F;
            5'd15:   atan_lut = 23'sh00001F;
            default: atan_lut = 23'sh000000;
        endcase
    endfunction

    // Chained micro-rotations; each step shifts the values left by the previous one.
    logic signed [23:0] x_rot, y_rot, x_t, y_t;
    logic signed [22:0] z_rot;
    logic [4:0]         k;

    always_comb begin
        x_rot = x;
        y_rot = y;
        z_rot = z;
        x_t   = '0;
        y_t   = '0;
        k     = '0;
        for (int s = 0; s < STEPS; s++) begin
            k   = i + 5'(s);
            x_t = x_rot;
            y_t = y_rot;
            if (y_t[23]) begin
                x_rot = x_t - (y_t >>> k);
                y_rot = y_t + (x_t >>> k);
                z_rot = z_rot - atan_lut(k);
            end else begin
                x_rot = x_t + (y_t >>> k);
                y_rot = y_t - (x_t >>> k);
                z_rot = z_rot + atan_lut(k);
            end
        end
    end

    logic signed [47:0] prod;
    logic signed [47:0] mag_full;
    logic [21:0]        mag_sat;
    logic signed [22:0] angle_fix;

    always_comb begin
        prod     = $signed({{24{x[23]}}, x}) * K_GAIN;
        mag_full = prod >>> 20;
        if (mag_full > MAG_MAX) begin
            mag_sat = 22'h1FFFFF;
        end else if (mag_full < 48'sd0) begin
            mag_sat = '0;
        end else begin
            mag_sat = mag_full[21:0];
        end
        // The negative real axis can land on -pi; report it as +pi instead.
        angle_fix = (z <= NEG_PI) ? PI : z;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            i         <= '0;
            zero_f    <= 1'b0;
            angle_out <= '0;
            mag_out   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clk_en) begin
                        x      <= {{2{x_in[21]}}, x_in};
                        y      <= {{2{y_in[21]}}, y_in};
                        zero_f <= (x_in == '0) && (y_in == '0);
                        busy   <= 1'b1;
                        state  <= PREROT;
                    end
                end
                PREROT: begin
                    if (!x[23]) begin
                        z <= '0;
                    end else if (!y[23]) begin
                        x <= y;
                        y <= -x;
                        z <= HALF_PI;
                    end else begin
                        x <= -y;
                        y <= x;
                        z <= -HALF_PI;
                    end
                    i     <= '0;
                    state <= ITER;
                end
                ITER: begin
                    x <= x_rot;
                    y <= y_rot;
                    z <= z_rot;
                    i <= i + STEPS_W;
                    if ((i + STEPS_W) == ITERS_W) begin
                        state <= SCALE;
                    end
                end
                SCALE: begin
                    angle_out <= zero_f ? '0 : angle_fix;
                    mag_out   <= zero_f ? '0 : mag_sat;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cordic_vectoring_rolled.sv
`default_nettype none
// ============================================================================
// tb_cordic_vectoring_rolled
//   Scoreboard bench: directed points with hand-computed polar results.
//   Rev 1.0
// ============================================================================
module tb_cordic_vectoring_rolled;

    logic               clk = 1'b0;
    logic               reset;
    logic               clk_en;
    logic signed [21:0] x_in;
    logic signed [21:0] y_in;
    logic signed [22:0] angle_out;
    logic        [21:0] mag_out;
    logic               busy;
    logic               done;

    always #5 clk = ~clk;

    cordic_vectoring_rolled #(.ITERS(16), .STEPS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .x_in      (x_in),
        .y_in      (y_in),
        .angle_out (angle_out),
        .mag_out   (mag_out),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        int ang;
        int mag;
        int tol;
        int start;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   held_a = 0;
    int   held_m = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp, input int tol);
        int d;
        d = act - exp;
        total++;
        if (d > tol || d < -tol) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", name, act, exp, tol, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done, otherwise checks outputs hold.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            chk("rst_angle", int'(angle_out), 0, 0);
            chk("rst_mag", int'(mag_out), 0, 0);
            chk("rst_busy", int'(busy), 0, 0);
            chk("rst_done", int'(done), 0, 0);
            held_a    = 0;
            held_m    = 0;
            prev_done = 1'b0;
        end else if (done) begin
            chk("done_width", int'(prev_done), 0, 0);
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0, 0);
            end else begin
                e = q.pop_front();
                chk("angle", int'(angle_out), e.ang, e.tol);
                chk("mag", int'(mag_out), e.mag, e.tol);
                chk("latency", cyc - e.start, 6, 0);
                chk("busy_at_done", int'(busy), 0, 0);
            end
            held_a    = int'(angle_out);
            held_m    = int'(mag_out);
            prev_done = 1'b1;
        end else begin
            chk("hold_angle", int'(angle_out), held_a, 0);
            chk("hold_mag", int'(mag_out), held_m, 0);
            prev_done = 1'b0;
        end
    end

    task automatic start(input int xv, input int yv, input int ang, input int mag, input int tol);
        @(negedge clk);
        clk_en = 1'b1;
        x_in   = 22'(xv);
        y_in   = 22'(yv);
        @(posedge clk);
        #1;
        q.push_back('{ang, mag, tol, cyc});
        chk("busy_after_start", int'(busy), 1, 0);
        clk_en = 1'b0;
        x_in   = 22'($urandom);
        y_in   = 22'($urandom);
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL timeout: %0d results still pending, expected 0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    localparam int TOL = 64;

    initial begin
        reset  = 1'b0;
        clk_en = 1'b0;
        x_in   = '0;
        y_in   = '0;
        #1;
        chk("init_angle", int'(angle_out), 0, 0);
        chk("init_busy", int'(busy), 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Directed points: positive axis, 45 deg, negative axis, folds.
        start(32'h080000, 0, 0, 32'h080000, TOL);              wait_empty();
        start(32'h080000, 32'h080000, 32'h0C90FD, 32'h0B504F, TOL); wait_empty();
        start(-32'h080000, 0, 32'h3243F6, 32'h080000, TOL);    wait_empty();
        start(0, -32'h100000, -32'h1921FB, 32'h100000, TOL);   wait_empty();
        start(-32'h080000, -32'h080000, -32'h25B2F9, 32'h0B504F, TOL); wait_empty();
        start(0, 32'h100000, 32'h1921FB, 32'h100000, TOL);     wait_empty();
        start(32'h080000, -32'h080000, -32'h0C90FD, 32'h0B504F, TOL); wait_empty();
        start(-32'h080000, 32'h080000, 32'h25B2F9, 32'h0B504F, TOL); wait_empty();
        start(-32'h100000, 0, 32'h3243F6, 32'h100000, TOL);    wait_empty();
        start(0, 0, 0, 0, 0);                                  wait_empty();

        // clk_en held high: back-to-back operations every 7 cycles.
        @(negedge clk);
        clk_en = 1'b1;
        x_in   = '0;
        y_in   = '0;
        @(posedge clk);
        #1;
        q.push_back('{0, 0, 0, cyc});
        x_in = 22'h080000;
        y_in = 22'h080000;
        repeat (7) @(posedge clk);
        #1;
        q.push_back('{32'h0C90FD, 32'h0B504F, TOL, cyc});
        x_in = 22'(-32'h080000);
        y_in = '0;
        repeat (7) @(posedge clk);
        #1;
        q.push_back('{32'h3243F6, 32'h080000, TOL, cyc});
        clk_en = 1'b0;
        wait_empty();

        // Start pulses while busy must be ignored.
        start(32'h100000, 0, 0, 32'h100000, TOL);
        for (int p = 0; p < 2; p++) begin
            @(negedge clk);
            clk_en = 1'b1;
            x_in   = 22'(-32'h0C0000);
            y_in   = 22'h030000;
            @(negedge clk);
            clk_en = 1'b0;
        end
        wait_empty();
        repeat (8) @(negedge clk);

        // Reset in the middle of ITER aborts with no done pulse.
        start(32'h080000, 32'h080000, 32'h0C90FD, 32'h0B504F, TOL);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        q.delete();
        chk("abort_angle", int'(angle_out), 0, 0);
        chk("abort_mag", int'(mag_out), 0, 0);
        chk("abort_busy", int'(busy), 0, 0);
        chk("abort_done", int'(done), 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        start(-32'h080000, -32'h080000, -32'h25B2F9, 32'h0B504F, TOL);
        wait_empty();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
